// File: rtl/mmu_page_walker.sv
// Two-level Sv32-style hardware page-table walker.
// Single outstanding PTE read; returns a PFN or a page fault.
module mmu_page_walker #(
  parameter int ADDR_WIDTH        = 32,
  parameter int VPN_WIDTH         = 20,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int PTE_WIDTH         = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-PAGE_OFFSET_WIDTH-1:0] root_ppn,
  input  logic                                  ptw_req_valid,
  input  logic [VPN_WIDTH-1:0]                  ptw_req_vpn,
  output logic                                  ptw_req_ready,
  output logic                                  ptw_resp_valid,
  output logic [ADDR_WIDTH-PAGE_OFFSET_WIDTH-1:0] ptw_resp_pfn,
  output logic                                  ptw_resp_fault,
  input  logic                                  ptw_resp_ready,
  output logic                                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
  input  logic                                  mem_req_ready,
  input  logic                                  mem_resp_valid,
  input  logic [PTE_WIDTH-1:0]                  mem_resp_data,
  input  logic                                  mem_resp_err
);

  localparam int PFN_W = ADDR_WIDTH - PAGE_OFFSET_WIDTH;
  localparam int LVL_W = VPN_WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L2_REQ,
    S_L2_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [VPN_WIDTH-1:0] r_vpn;
  logic [PFN_W-1:0]   r_root;
  logic [PFN_W-1:0]   r_pte_ppn;
  logic [PFN_W-1:0]   r_pfn;
  logic               r_fault;

  logic [PFN_W-1:0]   w_pte_ppn;
  logic               w_pte_v;
  logic               w_pte_l;
  logic               w_l1_fault;
  logic               w_l2_fault;
  logic               w_unused;

  assign w_pte_ppn  = mem_resp_data[PAGE_OFFSET_WIDTH +: PFN_W];
  assign w_pte_v    = mem_resp_data[0];
  assign w_pte_l    = mem_resp_data[1];
  assign w_unused   = &{1'b0, mem_resp_data[PAGE_OFFSET_WIDTH-1:2]};
  // Superpages are unsupported, so a level-1 leaf is a fault.
  assign w_l1_fault = mem_resp_err | ~w_pte_v | w_pte_l;
  assign w_l2_fault = mem_resp_err | ~w_pte_v | ~w_pte_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vpn     <= '0;
      r_root    <= '0;
      r_pte_ppn <= '0;
      r_pfn     <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (ptw_req_valid) begin
            r_vpn   <= ptw_req_vpn;
            r_root  <= root_ppn;
            r_pfn   <= '0;
            r_fault <= 1'b0;
          end
        end
        S_L1_WAIT: begin
          if (mem_resp_valid) begin
            r_pte_ppn <= w_pte_ppn;
            r_pfn     <= '0;
            r_fault   <= w_l1_fault;
          end
        end
        S_L2_WAIT: begin
          if (mem_resp_valid) begin
            r_pfn   <= w_l2_fault ? '0 : w_pte_ppn;
            r_fault <= w_l2_fault;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    ptw_req_ready  = 1'b0;
    ptw_resp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    unique case (r_state)
      S_IDLE: begin
        ptw_req_ready = 1'b1;
        if (ptw_req_valid) w_next = S_L1_REQ;
      end
      S_L1_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_root, r_vpn[VPN_WIDTH-1 -: LVL_W], 2'b00};
        if (mem_req_ready) w_next = S_L1_WAIT;
      end
      S_L1_WAIT: begin
        if (mem_resp_valid) w_next = w_l1_fault ? S_RESP : S_L2_REQ;
      end
      S_L2_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_pte_ppn, r_vpn[LVL_W-1:0], 2'b00};
        if (mem_req_ready) w_next = S_L2_WAIT;
      end
      S_L2_WAIT: begin
        if (mem_resp_valid) w_next = S_RESP;
      end
      S_RESP: begin
        ptw_resp_valid = 1'b1;
        if (ptw_resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign ptw_resp_pfn   = r_pfn;
  assign ptw_resp_fault = r_fault;

endmodule

// File: tb/tb_mmu_page_walker.sv
// Directed bench for mmu_page_walker with a behavioural
// PTE memory that can stall requests, delay or error responses.
module tb_mmu_page_walker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] root_ppn;
  logic        ptw_req_valid;
  logic [19:0] ptw_req_vpn;
  logic        ptw_req_ready;
  logic        ptw_resp_valid;
  logic [19:0] ptw_resp_pfn;
  logic        ptw_resp_fault;
  logic        ptw_resp_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  int total = 0;
  int bad   = 0;

  int   rd_idx;
  int   k_stall [2];
  int   k_dly   [2];
  bit   k_err   [2];
  logic [31:0] q_addr [$];

  always #5 clk = ~clk;

  mmu_page_walker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .root_ppn       (root_ppn),
    .ptw_req_valid  (ptw_req_valid),
    .ptw_req_vpn    (ptw_req_vpn),
    .ptw_req_ready  (ptw_req_ready),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_pfn   (ptw_resp_pfn),
    .ptw_resp_fault (ptw_resp_fault),
    .ptw_resp_ready (ptw_resp_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0010_0000: return 32'h0020_0001;
      32'h0020_000C: return 32'h0000_D003;
      32'h0010_0004: return 32'h0000_0000;
      32'h0020_0010: return 32'h0005_5001;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory model: decides ready at each falling edge, answers
  // k_dly cycles after the handshake edge.
  initial begin
    int          stall;
    int          dly;
    bit          pending;
    bit          in_req;
    logic [31:0] p_data;
    bit          p_err;
    stall = 0; dly = 0; pending = 0; in_req = 0;
    p_data = '0; p_err = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
      if (pending) begin
        if (dly == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = p_data;
          mem_resp_err   = p_err;
          pending = 0;
        end else dly--;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          stall  = (rd_idx < 2) ? k_stall[rd_idx] : 0;
        end
        if (stall > 0) stall--;
        else begin
          mem_req_ready = 1'b1;
          in_req  = 0;
          q_addr.push_back(mem_req_addr);
          p_data  = mem_word(mem_req_addr);
          p_err   = (rd_idx < 2) ? k_err[rd_idx] : 1'b0;
          dly     = (rd_idx < 2) ? k_dly[rd_idx] : 0;
          pending = 1;
          rd_idx++;
        end
      end
    end
  end

  task automatic setup(input int s0, input int d1, input bit e1);
    rd_idx = 0;
    q_addr.delete();
    k_stall[0] = s0; k_stall[1] = 0;
    k_dly[0]   = 0;  k_dly[1]   = d1;
    k_err[0]   = 0;  k_err[1]   = e1;
  endtask

  // Accepts at edge T; returns at the falling edge after T.
  task automatic issue(input logic [19:0] vpn);
    @(negedge clk);
    ptw_req_vpn   = vpn;
    root_ppn      = 20'h00100;
    ptw_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ptw_req_valid = 1'b0;
    ptw_req_vpn   = 20'hFFFFF;
    root_ppn      = 20'hABCDE;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!ptw_resp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (ptw_req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_req_ready got %b want 1", ptw_req_ready);
    end
    total++;
    if (ptw_resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_resp_valid got %b want 0", ptw_resp_valid);
    end
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mem_valid got %b want 0", mem_req_valid);
    end
    total++;
    if (mem_req_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mem_addr got %h want 0", mem_req_addr);
    end
    total++;
    if ({ptw_resp_pfn, ptw_resp_fault} !== 21'h0) begin
      bad++;
      $display("FAIL rst_resp got %h/%b want 0/0", ptw_resp_pfn, ptw_resp_fault);
    end
  endtask

  task automatic test_walk_ok;
    int cyc;
    setup(0, 0, 0);
    issue(20'h00003);
    wait_resp(cyc);
    total++;
    if (cyc !== 4) begin
      bad++; $display("FAIL ok_latency got %0d want 4", cyc);
    end
    total++;
    if (ptw_resp_pfn !== 20'h0000D || ptw_resp_fault !== 1'b0) begin
      bad++;
      $display("FAIL ok_resp got %h/%b want 0000d/0", ptw_resp_pfn, ptw_resp_fault);
    end
    total++;
    if (q_addr.size() != 2) begin
      bad++; $display("FAIL ok_reads got %0d want 2", q_addr.size());
    end else begin
      total++;
      if (q_addr[0] !== 32'h0010_0000 || q_addr[1] !== 32'h0020_000C) begin
        bad++;
        $display("FAIL ok_addrs got %h,%h want 00100000,0020000c", q_addr[0], q_addr[1]);
      end
    end
    @(negedge clk);
    total++;
    if (ptw_resp_valid !== 1'b0 || ptw_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ok_drop got v=%b r=%b want 0/1", ptw_resp_valid, ptw_req_ready);
    end
  endtask

  task automatic test_l1_invalid;
    int cyc;
    setup(0, 0, 0);
    issue(20'h00400);
    wait_resp(cyc);
    total++;
    if (cyc !== 2) begin
      bad++; $display("FAIL l1inv_latency got %0d want 2", cyc);
    end
    total++;
    if (ptw_resp_pfn !== 20'h0 || ptw_resp_fault !== 1'b1) begin
      bad++;
      $display("FAIL l1inv_resp got %h/%b want 0/1", ptw_resp_pfn, ptw_resp_fault);
    end
    repeat (3) @(negedge clk);
    total++;
    if (q_addr.size() != 1) begin
      bad++; $display("FAIL l1inv_reads got %0d want 1", q_addr.size());
    end else begin
      total++;
      if (q_addr[0] !== 32'h0010_0004) begin
        bad++; $display("FAIL l1inv_addr got %h want 00100004", q_addr[0]);
      end
    end
  endtask

  task automatic test_l2_nonleaf;
    int cyc;
    setup(0, 0, 0);
    issue(20'h00004);
    wait_resp(cyc);
    total++;
    if (cyc !== 4 || ptw_resp_fault !== 1'b1 || ptw_resp_pfn !== 20'h0) begin
      bad++;
      $display("FAIL nonleaf got cyc=%0d %h/%b want 4 0/1", cyc, ptw_resp_pfn, ptw_resp_fault);
    end
    total++;
    if (q_addr.size() != 2) begin
      bad++; $display("FAIL nonleaf_reads got %0d want 2", q_addr.size());
    end else begin
      total++;
      if (q_addr[1] !== 32'h0020_0010) begin
        bad++; $display("FAIL nonleaf_addr got %h want 00200010", q_addr[1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_bus_error;
    int cyc;
    setup(0, 0, 1);
    issue(20'h00003);
    wait_resp(cyc);
    total++;
    if (cyc !== 4 || ptw_resp_fault !== 1'b1 || ptw_resp_pfn !== 20'h0) begin
      bad++;
      $display("FAIL buserr got cyc=%0d %h/%b want 4 0/1", cyc, ptw_resp_pfn, ptw_resp_fault);
    end
    @(negedge clk);
  endtask

  task automatic test_stalls;
    int cyc;
    int l1_cyc;
    int l2_cyc;
    int odd;
    int rdy_hi;
    int unstable;
    setup(3, 2, 0);
    ptw_resp_ready = 1'b0;
    issue(20'h00003);
    cyc = 0; l1_cyc = 0; l2_cyc = 0; odd = 0; rdy_hi = 0;
    while (!ptw_resp_valid && cyc < 60) begin
      if (mem_req_valid) begin
        if (mem_req_addr === 32'h0010_0000) l1_cyc++;
        else if (mem_req_addr === 32'h0020_000C) l2_cyc++;
        else odd++;
      end
      if (ptw_req_ready !== 1'b0) rdy_hi++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 9) begin
      bad++; $display("FAIL stall_latency got %0d want 9", cyc);
    end
    total++;
    if (l1_cyc !== 4 || l2_cyc !== 1 || odd !== 0) begin
      bad++;
      $display("FAIL stall_addr got l1=%0d l2=%0d odd=%0d want 4/1/0", l1_cyc, l2_cyc, odd);
    end
    unstable = 0;
    repeat (4) begin
      if (ptw_resp_valid !== 1'b1 || ptw_resp_pfn !== 20'h0000D ||
          ptw_resp_fault !== 1'b0 || mem_req_valid !== 1'b0) unstable++;
      if (ptw_req_ready !== 1'b0) rdy_hi++;
      @(negedge clk);
    end
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL stall_hold got %0d unstable cycles want 0", unstable);
    end
    total++;
    if (rdy_hi !== 0) begin
      bad++; $display("FAIL stall_req_ready got %0d high cycles want 0", rdy_hi);
    end
    ptw_resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ptw_resp_valid !== 1'b0 || ptw_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got v=%b r=%b want 0/1", ptw_resp_valid, ptw_req_ready);
    end
  endtask

  task automatic test_reset_mid_walk;
    int cyc;
    int spur;
    setup(0, 4, 0);
    issue(20'h00003);
    cyc = 0;
    while (q_addr.size() < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (ptw_req_ready !== 1'b1 || mem_req_valid !== 1'b0 ||
        ptw_resp_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL midrst_outputs got rdy=%b mv=%b rv=%b a=%h want 1/0/0/0",
               ptw_req_ready, mem_req_valid, ptw_resp_valid, mem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    repeat (8) begin
      @(negedge clk);
      if (ptw_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
          ptw_req_ready !== 1'b1) spur++;
    end
    total++;
    if (spur !== 0) begin
      bad++; $display("FAIL midrst_stale got %0d bad cycles want 0", spur);
    end
    setup(0, 0, 0);
    issue(20'h00003);
    wait_resp(cyc);
    total++;
    if (cyc !== 4 || ptw_resp_pfn !== 20'h0000D || ptw_resp_fault !== 1'b0) begin
      bad++;
      $display("FAIL midrst_rewalk got cyc=%0d %h/%b want 4 0000d/0", cyc, ptw_resp_pfn, ptw_resp_fault);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    root_ppn       = 20'h0;
    ptw_req_valid  = 1'b0;
    ptw_req_vpn    = 20'h0;
    ptw_resp_ready = 1'b1;
    setup(0, 0, 0);
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_reset;
    test_walk_ok;
    test_l1_invalid;
    test_l2_nonleaf;
    test_bus_error;
    test_stalls;
    test_reset_mid_walk;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
